i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (slave) responder: the bus end answering an I2C controller built from the team's counters and shifters.
- Oversamples SCL/SDA on the system clock. Detects START, STOP and repeated START. Matches a 7-bit address.
- Exposes a byte-wide register port with an auto-incrementing pointer, in the common "pointer byte, then data" register-access style.
- Sits between the pad-level open-drain SDA buffer and a register bank.

Parameters:
- ADDR, 7'h42: 7-bit target address.
- NREG, 16: number of registers. Must be a power of two, ≥2. Pointer width AW = $clog2(NREG).

Ports:
- clk  in  1  system clock, ≥8x SCL rate.
- rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- reg_addr  out  AW  current register pointer.
- reg_wdata  out  8  received data byte.
- reg_we  out  1  one-clk write strobe.
- reg_rdata  in  8  read data for reg_addr; combinational from the bank.
- busy  out  1  high from an address-matched START until the next STOP or START.

Behaviour:
- Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, state=IDLE, bit counter=0.
- Input path: 2-flop synchronizer on scl_i and sda_i, plus one history flop each.
  - scl_rise / scl_fall: single-cycle pulses from the synchronized samples.
  - START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1.
- Timing rules:
  - Data is sampled on scl_rise.
  - sda_oe changes only on scl_fall.
  - Exception: STOP, START and reset clear sda_oe immediately.
- Bit counter: 3-bit, counts 7 down to 0 on data bits, then the ACK slot.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first.
  - ADDR_ACK:
    - Address mismatch -> IGNORE, sda_oe stays 0.
    - Match: drive ACK (sda_oe=1) on the fall after bit 0; busy=1.
    - On the next scl_fall, release ACK. Then R/W=0 -> PTR. R/W=1 -> load shift register from reg_rdata, drive MSB -> READ.
  - PTR: shift 8 bits. reg_addr <= byte[AW-1:0] one clk after the 8th rise. ACK -> WRITE.
  - WRITE: shift 8 bits.
    - One clk after the 8th rise: reg_wdata <= byte, reg_we=1 for exactly one clk.
    - Next clk: reg_addr <= reg_addr+1, wrapping NREG-1 -> 0.
    - ACK every byte, then stay in WRITE.
  - READ: drive bits on scl_fall; sda_oe = ~bit. After 8 bits, release SDA -> RACK.
  - RACK: sample the controller's ACK on scl_rise.
    - SDA=0 (ACK): reg_addr <= reg_addr+1 (wrapping); next scl_fall loads reg_rdata and drives MSB -> READ.
    - SDA=1 (NACK): -> IGNORE, pointer unchanged.
  - IGNORE: sda_oe=0; wait for STOP/START.
- STOP in any state: -> IDLE, busy=0, sda_oe=0. A partial byte is discarded; no reg_we.
- START in any state (repeated START): -> ADDR, bit counter reset, sda_oe=0. reg_addr is retained, so pointer-write + Sr + read works.
- General call (0x00) is not acknowledged.
- Simultaneous events: a STOP/START detection has priority over a scl edge in the same clk.
- Asynchronous reset mid-transfer: all outputs to reset values at once; the bus is released.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter after the synchronizer on both SCL and SDA. Pulses ≤1 clk wide are rejected. Edge detection latency grows by 2 clks.
- Undefined: no filter; synchronizer-only latency of 2 clks to the synchronized value, plus 1 clk for edge detection.

Test Plan:
- Write: START, 0x84 (addr 0x42, W), 0x03, 0xA5, 0x5A, STOP.
  - ACK on all 4 bytes.
  - reg_we pulses twice: addr 3 data 0xA5, then addr 4 data 0x5A.
  - reg_addr=5 after; busy 1->0 at STOP.
- Read with repeated START: START, 0x84, 0x0E, Sr, 0x85, read 3 bytes (ACK, ACK, NACK) with bank[i]=i*0x11.
  - SDA returns 0xEE, 0xFF, 0x00 (pointer wraps 15->0).
  - reg_addr=0 at the end.
- Address mismatch: START, 0x86, 0x01, 0xFF, STOP.
  - sda_oe never asserts; no reg_we; busy stays 0.
- Abort: STOP after 4 bits of a data byte in WRITE.
  - No reg_we; state IDLE; a following START + 0x84 is ACKed normally.
- Reset: assert rst while driving bit 2 of a READ byte.
  - sda_oe=0 within the same clk; all outputs at reset values; the next transaction works.
- With I2C_TARGET_GLITCH_FILTER_EN: 1-clk low glitch on SCL during a data bit.
  - No extra bit sampled; byte 0x3C received intact.

Source files
------------

// File: rtl/i2c_target_if.sv
// I2C target bus-side and register-port signal bundle.
// slave: the target's view; master: the controller/register-bank side.
`timescale 1ns/1ps
interface i2c_target_if #(
  parameter int NREG = 16
);
  localparam int AW = $clog2(NREG);

  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic [7:0]    reg_rdata;
  logic          busy;

  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, busy
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, busy
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target responder: 7-bit address match, pointer byte then data,
// auto-incrementing register pointer, open-drain SDA via sda_oe.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority
// filter on SCL/SDA after the synchronizers (+2 clk latency).
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42,
  parameter int         NREG = 16
) (
  input  logic         clk,
  input  logic         rst,
  i2c_target_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WRITE, S_WR_ACK, S_READ, S_RACK, S_IGNORE
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_h, r_sda_h;
  logic w_scl, w_sda;

  // two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= bus.scl_i;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= bus.sda_i;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_scl_m, r_sda_m;
  logic       r_scl_f, r_sda_f;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // majority vote over current and two previous samples rejects 1-clk pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_m <= 2'b11;
      r_sda_m <= 2'b11;
      r_scl_f <= 1'b1;
      r_sda_f <= 1'b1;
    end else begin
      r_scl_m <= {r_scl_m[0], r_scl_s2};
      r_sda_m <= {r_sda_m[0], r_sda_s2};
      r_scl_f <= maj3({r_scl_m, r_scl_s2});
      r_sda_f <= maj3({r_sda_m, r_sda_s2});
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  // one-sample history for edge and START/STOP detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_h <= 1'b1;
      r_sda_h <= 1'b1;
    end else begin
      r_scl_h <= w_scl;
      r_sda_h <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_h;
  assign w_scl_fall = ~w_scl & r_scl_h;
  assign w_start    = w_scl & r_scl_h & r_sda_h & ~w_sda;
  assign w_stop     = w_scl & r_scl_h & ~r_sda_h & w_sda;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_ack, w_ack_nxt;      // ACK slot in progress / controller ACK seen
  logic [1:0]    r_pend, w_pend_nxt;    // 1: byte just completed, 2: post-write increment
  logic          r_sda_oe, w_sda_oe_nxt;
  logic [AW-1:0] r_reg_addr, w_reg_addr_nxt;
  logic [7:0]    r_reg_wdata, w_reg_wdata_nxt;
  logic          r_reg_we, w_reg_we_nxt;
  logic          r_busy, w_busy_nxt;

  logic [AW-1:0] w_addr_inc;
  assign w_addr_inc = r_reg_addr + {{(AW-1){1'b0}}, 1'b1};

  // state and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_ack       <= 1'b0;
      r_pend      <= 2'd0;
      r_sda_oe    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= 8'd0;
      r_reg_we    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_pend      <= w_pend_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_reg_we    <= w_reg_we_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // shift register is pure data and needs no reset
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // next-state and output logic; bus conditions win over SCL edges
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_ack_nxt       = r_ack;
    w_pend_nxt      = r_pend;
    w_sda_oe_nxt    = r_sda_oe;
    w_reg_addr_nxt  = r_reg_addr;
    w_reg_wdata_nxt = r_reg_wdata;
    w_reg_we_nxt    = 1'b0;
    w_busy_nxt      = r_busy;
    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = 3'd0;
      w_ack_nxt    = 1'b0;
      w_pend_nxt   = 2'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_cnt_nxt    = 3'd7;
      w_ack_nxt    = 1'b0;
      w_pend_nxt   = 2'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WRITE: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            if (r_cnt == 3'd0) begin
              w_pend_nxt = 2'd1;
              w_state_nxt = (r_state == S_ADDR) ? S_ADDR_ACK :
                            (r_state == S_PTR)  ? S_PTR_ACK  : S_WR_ACK;
            end else begin
              w_cnt_nxt = r_cnt - 3'd1;
            end
          end
        end
        S_ADDR_ACK: begin
          w_pend_nxt = 2'd0;
          if (w_scl_fall) begin
            if (!r_ack) begin
              if (r_shift[7:1] == ADDR && r_shift[7:1] != 7'd0) begin
                w_sda_oe_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
                w_ack_nxt    = 1'b1;
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end else begin
              w_ack_nxt = 1'b0;
              w_cnt_nxt = 3'd7;
              if (r_shift[0]) begin
                w_shift_nxt  = bus.reg_rdata;
                w_sda_oe_nxt = ~bus.reg_rdata[7];
                w_state_nxt  = S_READ;
              end else begin
                w_sda_oe_nxt = 1'b0;
                w_state_nxt  = S_PTR;
              end
            end
          end
        end
        S_PTR_ACK, S_WR_ACK: begin
          if (r_pend == 2'd1 && r_state == S_PTR_ACK) begin
            w_reg_addr_nxt = r_shift[AW-1:0];
            w_pend_nxt     = 2'd0;
          end else if (r_pend == 2'd1) begin
            w_reg_wdata_nxt = r_shift;
            w_reg_we_nxt    = 1'b1;
            w_pend_nxt      = 2'd2;
          end else if (r_pend == 2'd2) begin
            w_reg_addr_nxt = w_addr_inc;
            w_pend_nxt     = 2'd0;
          end
          if (w_scl_fall) begin
            if (!r_ack) begin
              w_sda_oe_nxt = 1'b1;
              w_ack_nxt    = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_ack_nxt    = 1'b0;
              w_cnt_nxt    = 3'd7;
              w_state_nxt  = S_WRITE;
            end
          end
        end
        S_READ: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_oe_nxt = 1'b0;
              w_ack_nxt    = 1'b0;
              w_state_nxt  = S_RACK;
            end else begin
              w_cnt_nxt    = r_cnt - 3'd1;
              w_sda_oe_nxt = ~r_shift[6];
              w_shift_nxt  = {r_shift[6:0], 1'b0};
            end
          end
        end
        S_RACK: begin
          if (!r_ack) begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                w_reg_addr_nxt = w_addr_inc;
                w_ack_nxt      = 1'b1;
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end
          end else if (w_scl_fall) begin
            w_ack_nxt    = 1'b0;
            w_shift_nxt  = bus.reg_rdata;
            w_sda_oe_nxt = ~bus.reg_rdata[7];
            w_cnt_nxt    = 3'd7;
            w_state_nxt  = S_READ;
          end
        end
        S_IGNORE: w_sda_oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = r_sda_oe;
  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_wdata = r_reg_wdata;
  assign bus.reg_we    = r_reg_we;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_i2c_target.sv
// Testbench for i2c_target: bit-banged I2C controller, open-drain SDA model,
// register bank returning {addr,addr}; write and read-data scoreboards.
`timescale 1ns/1ps
module tb_i2c_target;
  localparam int QT = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  always #5 clk = ~clk;

  i2c_target_if #(.NREG(16)) bus();
  assign bus.scl_i     = m_scl;
  assign bus.sda_i     = m_sda & ~bus.sda_oe;
  assign bus.reg_rdata = {bus.reg_addr, bus.reg_addr};

  i2c_target #(.ADDR(7'h42), .NREG(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [11:0] wr_got[$];
  logic [11:0] wr_exp[$];
  logic [7:0]  rd_exp[$];

  always @(negedge clk) begin
    if (bus.reg_we) begin
      wr_got.push_back({bus.reg_addr, bus.reg_wdata});
      we_cnt++;
    end
    if (bus.sda_oe) oe_cnt++;
    if (bus.busy) busy_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    if (m_scl) begin
      m_sda = 1'b0; #QT; m_scl = 1'b0; #QT;
    end else begin
      m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; m_sda = 1'b0; #QT; m_scl = 1'b0; #QT;
    end
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #QT; m_scl = 1'b1; #QT; m_sda = 1'b1; #(2*QT);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; #QT; m_scl = 1'b1; #(2*QT); m_scl = 1'b0; #QT;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; ack = bus.sda_i; #QT; m_scl = 1'b0; #QT;
  endtask

  task automatic get_byte(input logic ack_bit, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; b = {b[6:0], bus.sda_i}; #QT; m_scl = 1'b0; #QT;
    end
    put_bit(ack_bit);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk); #2;
    n_tests++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", bus.sda_oe); end
    n_tests++; if (bus.reg_addr !== 4'd0) begin n_fail++; $display("FAIL reset_reg_addr got %h want 0", bus.reg_addr); end
    n_tests++; if (bus.reg_wdata !== 8'd0) begin n_fail++; $display("FAIL reset_reg_wdata got %h want 0", bus.reg_wdata); end
    n_tests++; if (bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_reg_we got %b want 0", bus.reg_we); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_write();
    logic ack;
    i2c_start();
    send_byte(8'h84, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy got %b want 1", bus.busy); end
    send_byte(8'h03, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_ptr_ack got %b want 0", ack); end
    wr_exp.push_back({4'd3, 8'hA5});
    send_byte(8'hA5, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_d0_ack got %b want 0", ack); end
    wr_exp.push_back({4'd4, 8'h5A});
    send_byte(8'h5A, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_d1_ack got %b want 0", ack); end
    i2c_stop();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_stop got %b want 0", bus.busy); end
    n_tests++; if (bus.reg_addr !== 4'd5) begin n_fail++; $display("FAIL wr_reg_addr got %h want 5", bus.reg_addr); end
    while (wr_exp.size() > 0) begin
      logic [11:0] e = wr_exp.pop_front();
      n_tests++;
      if (wr_got.size() == 0) begin n_fail++; $display("FAIL wr_sb missing got none want %h", e); end
      else begin
        logic [11:0] g = wr_got.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL wr_sb got %h want %h", g, e); end
      end
    end
    n_tests++; if (wr_got.size() != 0) begin n_fail++; $display("FAIL wr_sb_extra got %0d want 0", wr_got.size()); wr_got.delete(); end
  endtask

  task automatic test_read_rs();
    logic ack;
    logic [7:0] b;
    logic [2:0] acks;
    acks = 3'b100;
    i2c_start();
    send_byte(8'h84, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_waddr_ack got %b want 0", ack); end
    send_byte(8'h0E, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_ptr_ack got %b want 0", ack); end
    i2c_start();
    send_byte(8'h85, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_raddr_ack got %b want 0", ack); end
    rd_exp.push_back(8'hEE); rd_exp.push_back(8'hFF); rd_exp.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      get_byte(acks[i], b);
      e = rd_exp.pop_front();
      n_tests++; if (b !== e) begin n_fail++; $display("FAIL rd_data%0d got %h want %h", i, b, e); end
    end
    i2c_stop();
    n_tests++; if (bus.reg_addr !== 4'd0) begin n_fail++; $display("FAIL rd_reg_addr got %h want 0", bus.reg_addr); end
    n_tests++; if (wr_got.size() != 0) begin n_fail++; $display("FAIL rd_no_write got %0d want 0", wr_got.size()); wr_got.delete(); end
  endtask

  task automatic test_mismatch();
    logic ack;
    int oe0, we0, busy0;
    oe0 = oe_cnt; we0 = we_cnt; busy0 = busy_cnt;
    i2c_start();
    send_byte(8'h86, ack);
    n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mm_addr_nack got %b want 1", ack); end
    send_byte(8'h01, ack);
    send_byte(8'hFF, ack);
    i2c_stop();
    n_tests++; if (oe_cnt != oe0) begin n_fail++; $display("FAIL mm_sda_oe got %0d want %0d", oe_cnt, oe0); end
    n_tests++; if (we_cnt != we0) begin n_fail++; $display("FAIL mm_reg_we got %0d want %0d", we_cnt, we0); end
    n_tests++; if (busy_cnt != busy0) begin n_fail++; $display("FAIL mm_busy got %0d want %0d", busy_cnt, busy0); end
  endtask

  task automatic test_abort();
    logic ack;
    int we0;
    we0 = we_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h07, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ab_ptr_ack got %b want 0", ack); end
    for (int i = 0; i < 4; i++) put_bit(i[0]);
    i2c_stop();
    n_tests++; if (we_cnt != we0) begin n_fail++; $display("FAIL ab_no_we got %0d want %0d", we_cnt, we0); end
    i2c_start();
    send_byte(8'h84, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ab_next_ack got %b want 0", ack); end
    i2c_stop();
    n_tests++; if (bus.reg_addr !== 4'd7) begin n_fail++; $display("FAIL ab_reg_addr got %h want 7", bus.reg_addr); end
    wr_got.delete();
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic [4:0] top;
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte(8'h85, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rm_addr_ack got %b want 0", ack); end
    top = 5'd0;
    for (int i = 0; i < 5; i++) begin
      m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; top = {top[3:0], bus.sda_i}; #QT; m_scl = 1'b0; #QT;
    end
    n_tests++; if (top !== 5'b00100) begin n_fail++; $display("FAIL rm_top_bits got %b want 00100", top); end
    n_tests++; if (bus.sda_oe !== 1'b1) begin n_fail++; $display("FAIL rm_driving got %b want 1", bus.sda_oe); end
    rst = 1'b1; #1;
    n_tests++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL rm_sda_oe got %b want 0", bus.sda_oe); end
    n_tests++; if (bus.reg_addr !== 4'd0) begin n_fail++; $display("FAIL rm_reg_addr got %h want 0", bus.reg_addr); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.reg_wdata !== 8'd0) begin n_fail++; $display("FAIL rm_reg_wdata got %h want 0", bus.reg_wdata); end
    repeat (3) @(posedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    i2c_stop();
    i2c_start();
    send_byte(8'h84, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rm_next_ack got %b want 0", ack); end
    send_byte(8'h09, ack);
    wr_exp.push_back({4'd9, 8'h77});
    send_byte(8'h77, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rm_data_ack got %b want 0", ack); end
    i2c_stop();
    while (wr_exp.size() > 0) begin
      logic [11:0] e = wr_exp.pop_front();
      n_tests++;
      if (wr_got.size() == 0) begin n_fail++; $display("FAIL rm_sb missing got none want %h", e); end
      else begin
        logic [11:0] g = wr_got.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL rm_sb got %h want %h", g, e); end
      end
    end
    n_tests++; if (bus.reg_addr !== 4'd10) begin n_fail++; $display("FAIL rm_final_addr got %h want a", bus.reg_addr); end
  endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic ack;
    logic [7:0] b;
    b = 8'h3C;
    wr_got.delete();
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h06, ack);
    wr_exp.push_back({4'd6, 8'h3C});
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; #QT; m_scl = 1'b1;
      if (i == 4) begin #QT; m_scl = 1'b0; #10; m_scl = 1'b1; #(QT-10); end
      else #(2*QT);
      m_scl = 1'b0; #QT;
    end
    m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; ack = bus.sda_i; #QT; m_scl = 1'b0; #QT;
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL gl_ack got %b want 0", ack); end
    i2c_stop();
    while (wr_exp.size() > 0) begin
      logic [11:0] e = wr_exp.pop_front();
      n_tests++;
      if (wr_got.size() == 0) begin n_fail++; $display("FAIL gl_sb missing got none want %h", e); end
      else begin
        logic [11:0] g = wr_got.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL gl_sb got %h want %h", g, e); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_rs();
    test_mismatch();
    test_abort();
    test_reset_mid();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
